// File: rtl/comparator_scan_sequencer.sv
// Steps a DAC threshold scan through comparator_injector and reports per-step error counts.
// Optional watchdog on the pulse handshake is built when SCAN_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | dac_value presented, dac_load strobe
// SETTLE | settle countdown after DAC load
// CLEAR  | errcnt_rst pulse to the injector
// FIRE   | fire_pulse high until pulser_ready drops
// WAIT   | waiting for pulser_ready to return
// REPORT | result held on valid/ready port
module comparator_scan_sequencer #(
  parameter int DAC_W    = 12,
  parameter int NPULSE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [NPULSE_W-1:0] num_pulses,
  input  logic [7:0]          num_steps,
  input  logic [DAC_W-1:0]    dac_start,
  input  logic [DAC_W-1:0]    dac_step,
  input  logic [7:0]          settle_cycles,
  output logic [DAC_W-1:0]    dac_value,
  output logic                dac_load,
  output logic                errcnt_rst,
  output logic                fire_pulse,
  input  logic                pulser_ready,
  input  logic [31:0]         halfstrips_errcnt,
  input  logic [31:0]         compout_errcnt,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [7:0]          result_step,
  output logic [31:0]         result_hs_errcnt,
  output logic [31:0]         result_co_errcnt,
  output logic                busy,
  output logic                done,
  output logic                timeout
);

  // one-hot so every strobe output is a flop bit with no decode glitches
  typedef enum logic [6:0] {
    S_IDLE   = 7'b0000001,
    S_LOAD   = 7'b0000010,
    S_SETTLE = 7'b0000100,
    S_CLEAR  = 7'b0001000,
    S_FIRE   = 7'b0010000,
    S_WAIT   = 7'b0100000,
    S_REPORT = 7'b1000000
  } state_t;

  localparam int I_IDLE   = 0;
  localparam int I_LOAD   = 1;
  localparam int I_SETTLE = 2;
  localparam int I_CLEAR  = 3;
  localparam int I_FIRE   = 4;
  localparam int I_WAIT   = 5;
  localparam int I_REPORT = 6;

  state_t              state, state_nx;
  logic [NPULSE_W-1:0] np_snap;
  logic [NPULSE_W-1:0] pulse_cnt;
  logic [7:0]          last_step;
  logic [7:0]          settle_snap;
  logic [7:0]          settle_cnt;
  logic [7:0]          step_idx;
  logic [DAC_W-1:0]    step_snap;
  logic                fire_held;
  logic                wd_expire;
  logic                last_accept;

  assign last_accept = state[I_REPORT] && result_ready && (step_idx == last_step);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_LOAD;
      S_LOAD:   state_nx = (settle_snap == 8'd0) ? S_CLEAR : S_SETTLE;
      S_SETTLE: if (settle_cnt <= 8'd1) state_nx = S_CLEAR;
      S_CLEAR:  state_nx = S_FIRE;
      // fire_held guarantees at least two cycles of fire_pulse
      S_FIRE:   if (!pulser_ready && fire_held) state_nx = S_WAIT;
      S_WAIT:   if (pulser_ready)
                  state_nx = (pulse_cnt <= NPULSE_W'(1)) ? S_REPORT : S_FIRE;
      S_REPORT: if (result_ready)
                  state_nx = (step_idx == last_step) ? S_IDLE : S_LOAD;
      default:  state_nx = S_IDLE;
    endcase
    if ((abort || wd_expire) && !state[I_IDLE]) state_nx = S_IDLE;
  end

  always_comb begin
    busy         = !state[I_IDLE];
    dac_load     = state[I_LOAD];
    errcnt_rst   = state[I_CLEAR];
    fire_pulse   = state[I_FIRE];
    result_valid = state[I_REPORT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      np_snap          <= '0;
      pulse_cnt        <= '0;
      last_step        <= '0;
      settle_snap      <= '0;
      settle_cnt       <= '0;
      step_idx         <= '0;
      step_snap        <= '0;
      dac_value        <= '0;
      fire_held        <= 1'b0;
      done             <= 1'b0;
      result_step      <= '0;
      result_hs_errcnt <= '0;
      result_co_errcnt <= '0;
    end else begin
      fire_held <= state[I_FIRE] && (state_nx == S_FIRE);
      done      <= last_accept && !abort;
      if (state[I_IDLE] && state_nx == S_LOAD) begin
        np_snap     <= (num_pulses == '0) ? NPULSE_W'(1) : num_pulses;
        last_step   <= (num_steps == 8'd0) ? 8'd0 : num_steps - 8'd1;
        settle_snap <= settle_cycles;
        step_snap   <= dac_step;
        step_idx    <= 8'd0;
        dac_value   <= dac_start;
      end
      if (state[I_LOAD])   settle_cnt <= settle_snap;
      if (state[I_SETTLE]) settle_cnt <= settle_cnt - 8'd1;
      if (state[I_CLEAR])  pulse_cnt  <= np_snap;
      if (state[I_WAIT] && pulser_ready) pulse_cnt <= pulse_cnt - NPULSE_W'(1);
      // injector counters are final once pulser_ready returns for the last pulse
      if (state[I_WAIT] && state_nx == S_REPORT) begin
        result_step      <= step_idx;
        result_hs_errcnt <= halfstrips_errcnt;
        result_co_errcnt <= compout_errcnt;
      end
      if (state[I_REPORT] && state_nx == S_LOAD) begin
        step_idx  <= step_idx + 8'd1;
        dac_value <= dac_value + step_snap;
      end
    end
  end

`ifdef SCAN_TIMEOUT_EN
  logic [9:0] wd_cnt;
  logic       timeout_r;

  assign wd_expire = (state[I_FIRE] || state[I_WAIT]) && (wd_cnt == 10'd1023);
  assign timeout   = timeout_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (!(state[I_FIRE] || state[I_WAIT]) || (state[I_WAIT] && pulser_ready))
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 10'd1;
      if (wd_expire)                      timeout_r <= 1'b1;
      else if (state[I_IDLE] && start)    timeout_r <= 1'b0;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule
